md_unit: RTL

Multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline's EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and holds a multi-cycle busy interval for arithmetic ops. It drives HI and LO continuously to the HI/LO read-select path, which serves MFHI/MFLO.
The hazard unit stalls on busy or start.

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_compute.sv | 68 ++++++
 rtl/md_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: command encodings,
// FSM state type, busy-counter width and command classification helpers.
package md_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Commands that occupy the unit for a multi-cycle busy interval.
    function automatic logic is_arith(input logic [2:0] op);
`ifdef MD_UNIT_MADD_EN
        return (op != MD_MTHI) && (op != MD_MTLO);
`else
        return !op[2];
`endif
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: 64-bit product / {remainder,quotient} result for
// the command on op_i, plus a divide-by-zero flag.
// Ports: a_i/b_i operands, op_i command, hi_i/lo_i current HI/LO (used as the
// accumulator when MD_UNIT_MADD_EN is defined), res_o {hi,lo}, dz_o.
module md_compute
    import md_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o,
    output logic        dz_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] dvs;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q;
    logic [31:0] r;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
    assign sgn = (op_i == MD_DIV);
    assign ua  = (sgn && a_i[31]) ? -a_i : a_i;
    assign ub  = (sgn && b_i[31]) ? -b_i : b_i;
    assign dvs = (b_i == 32'd0) ? 32'd1 : ub;
    assign q_u = ua / dvs;
    assign r_u = ua % dvs;
    assign q   = (sgn && (a_i[31] ^ b_i[31])) ? -q_u : q_u;
    assign r   = (sgn && a_i[31]) ? -r_u : r_u;

    assign dz_o = is_div(op_i) && (b_i == 32'd0);

`ifdef MD_UNIT_MADD_EN
    logic [63:0] acc_add;
    logic [63:0] acc_sub;
    assign acc_add = {hi_i, lo_i} + prod_s;
    assign acc_sub = {hi_i, lo_i} - prod_s;
`else
    logic unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
`endif

    always_comb begin
        res_o = '0;
        unique case (md_op_e'(op_i))
            MD_MULT:          res_o = prod_s;
            MD_MULTU:         res_o = prod_u;
            MD_DIV, MD_DIVU:  res_o = {r, q};
`ifdef MD_UNIT_MADD_EN
            MD_MADD:          res_o = acc_add;
            MD_MSUB:          res_o = acc_sub;
`endif
            default:          res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// MIPS EX-stage multiply/divide unit owning HI/LO. Results are latched at
// accept and committed to HI/LO on the edge busy falls.
// Ports: clk, reset (async, active-low), start/md_op/a/b command,
// busy, hi, lo. Optional MADD/MSUB via macro MD_UNIT_MADD_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             dz_q;
    logic             busy_q;
    logic [63:0]      res;
    logic             dz;

    md_compute u_compute (
        .a_i   (a),
        .b_i   (b),
        .op_i  (md_op),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (res),
        .dz_o  (dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_arith(md_op)) begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            cnt_q     <= is_div(md_op) ? DIV_N : MUL_N;
                            pend_hi_q <= res[63:32];
                            pend_lo_q <= res[31:0];
                            dz_q      <= dz;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                RUN: begin
                    // Commands arriving here are dropped.
                    if (cnt_q == 1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (!dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
